// File: rtl/chr_gen_pkg.sv
// Shared defaults and helpers for the character-generator scanout blocks.
// No logic of its own; imported by the scanout top and its sub-blocks.
// Holds raster geometry, memory latencies and a compile-time log2.
package chr_gen_pkg;

    localparam int DEF_CHR_W   = 8;
    localparam int DEF_ADR_W   = 12;
    localparam int DEF_COLS    = 80;
    localparam int DEF_ROWS    = 30;
    localparam int DEF_GLYPH_W = 8;
    localparam int DEF_GLYPH_H = 16;
    localparam int DEF_RAM_LAT = 2;
    localparam int DEF_ROM_LAT = 2;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/chr_scan_fetch_sig_dly.sv
// Fixed-depth register delay line for alignment of side-band signals.
// Latency: exactly N cycles from din to dout.
// No backpressure: shifts every cycle, async reset clears all stages.
module sig_dly #(
    parameter int W = 1,
    parameter int N = 1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [N];

    // Shift the sample one stage further along the line each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[N-1];

endmodule

// File: rtl/chr_scan_fetch.sv
// Text-mode scanout: raster counters -> VRAM fetch -> font ROM lookup -> 1-bit pixels.
// Latency: PIX_o/DE_o/VS_o trail DE_i/VS_i by C_RAM_LAT + C_ROM_LAT + 1 cycles.
// No backpressure: free-running pixel-clock pipeline, one pixel per cycle.
module chr_scan_fetch
    import chr_gen_pkg::*;
#(
    parameter int C_CHR_W   = DEF_CHR_W,
    parameter int C_ADR_W   = DEF_ADR_W,
    parameter int C_COLS    = DEF_COLS,
    parameter int C_ROWS    = DEF_ROWS,
    parameter int C_GLYPH_W = DEF_GLYPH_W,
    parameter int C_GLYPH_H = DEF_GLYPH_H,
    parameter int C_RAM_LAT = DEF_RAM_LAT,
    parameter int C_ROM_LAT = DEF_ROM_LAT
)(
    input  logic                                  CK_i,
    input  logic                                  ARST_i,
    input  logic                                  VS_i,
    input  logic                                  DE_i,
    output logic [C_ADR_W-1:0]                    RAs_o,
    input  logic [C_CHR_W-1:0]                    RDs_i,
    output logic [C_CHR_W+clog2(C_GLYPH_H)-1:0]   FAs_o,
    input  logic [C_GLYPH_W-1:0]                  FDs_i,
    output logic                                  PIX_o,
    output logic                                  DE_o,
    output logic                                  VS_o
);

    localparam int GL_W  = clog2(C_GLYPH_H);
    localparam int SUB_W = clog2(C_GLYPH_W);
    localparam int COL_W = clog2(C_COLS + 1);
    localparam int ROW_W = clog2(C_ROWS);
    localparam int L     = C_RAM_LAT + C_ROM_LAT + 1;

    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(C_GLYPH_W - 1);
    localparam logic [COL_W-1:0]   COL_END  = COL_W'(C_COLS);
    localparam logic [GL_W-1:0]    GL_LAST  = GL_W'(C_GLYPH_H - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(C_ROWS - 1);
    localparam logic [C_ADR_W-1:0] ROW_STEP = C_ADR_W'(C_COLS);

    // A frame larger than the address space would silently alias VRAM.
    if (C_COLS * C_ROWS > (1 << C_ADR_W)) begin : g_adr_chk
        $error("chr_scan_fetch: C_COLS*C_ROWS exceeds the VRAM address space");
    end

    logic [SUB_W-1:0]   sub;
    logic [COL_W-1:0]   col;
    logic [GL_W-1:0]    gl;
    logic [ROW_W-1:0]   row;
    logic [C_ADR_W-1:0] row_base;
    logic               de_q;

    logic               slot;
    logic               fetch;
    logic [C_ADR_W-1:0] fetch_adr;

    logic [GL_W-1:0]    gl_d;
    logic               slot_a;
    logic               fetch_a;
    logic               slot_b;
    logic               fetch_b;
    logic [1:0]         vid_d;

    logic [C_GLYPH_W-1:0] sreg;

    // Raster position: sub/col within the line, gl/row/row_base across lines; VS wins over the DE edge.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            sub      <= '0;
            col      <= '0;
            gl       <= '0;
            row      <= '0;
            row_base <= '0;
            de_q     <= 1'b0;
        end else begin
            de_q <= DE_i;
            if (VS_i) begin
                sub      <= '0;
                col      <= '0;
                gl       <= '0;
                row      <= '0;
                row_base <= '0;
            end else begin
                if (DE_i) begin
                    if (sub == SUB_LAST) begin
                        sub <= '0;
                        // Saturate past the last column so over-long lines never wrap back into range.
                        if (col != COL_END) col <= col + 1'b1;
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end else begin
                    sub <= '0;
                    col <= '0;
                end
                if (de_q && !DE_i) begin
                    if (gl == GL_LAST) begin
                        gl <= '0;
                        if (row == ROW_LAST) begin
                            row      <= '0;
                            row_base <= '0;
                        end else begin
                            row      <= row + 1'b1;
                            row_base <= row_base + ROW_STEP;
                        end
                    end else begin
                        gl <= gl + 1'b1;
                    end
                end
            end
        end
    end

    // Every glyph boundary (and every blank cycle) is a slot; only in-range active slots fetch.
    assign slot      = (sub == '0);
    assign fetch     = DE_i && slot && (col < COL_END);
    assign fetch_adr = row_base + C_ADR_W'(col);

    // Issue the VRAM read address; it holds between fetches.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) RAs_o <= '0;
        else if (fetch) RAs_o <= fetch_adr;
    end

    // Glyph line and slot/fetch flags ride alongside the VRAM read.
    sig_dly #(.W(GL_W + 2), .N(C_RAM_LAT)) u_ram_pipe (
        .clk  (CK_i),
        .rst  (ARST_i),
        .din  ({gl, slot, fetch}),
        .dout ({gl_d, slot_a, fetch_a})
    );

    // Form the font address from the returned code and the glyph line of that same fetch.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) FAs_o <= '0;
        else if (fetch_a) FAs_o <= {RDs_i, gl_d};
    end

    sig_dly #(.W(2), .N(C_ROM_LAT)) u_rom_pipe (
        .clk  (CK_i),
        .rst  (ARST_i),
        .din  ({slot_a, fetch_a}),
        .dout ({slot_b, fetch_b})
    );

    // Serializer: load a glyph row (or blank) at each slot, otherwise shift out MSB-first.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            sreg <= '0;
        end else if (slot_b) begin
            sreg <= fetch_b ? FDs_i : '0;
        end else begin
            sreg <= {sreg[C_GLYPH_W-2:0], 1'b0};
        end
    end

    sig_dly #(.W(2), .N(L)) u_vid_pipe (
        .clk  (CK_i),
        .rst  (ARST_i),
        .din  ({DE_i, VS_i}),
        .dout (vid_d)
    );

    assign DE_o  = vid_d[1];
    assign VS_o  = vid_d[0];
    assign PIX_o = sreg[C_GLYPH_W-1] & DE_o;

endmodule

// File: tb/tb_chr_scan_fetch.sv
// Bench for chr_scan_fetch: VRAM/font models, line-level reference model, directed and random lines.
module tb_chr_scan_fetch;

    logic        CK_i = 1'b0;
    logic        ARST_i;
    logic        VS_i;
    logic        DE_i;
    logic [11:0] RAs_o;
    logic [7:0]  RDs_i;
    logic [11:0] FAs_o;
    logic [7:0]  FDs_i;
    logic        PIX_o;
    logic        DE_o;
    logic        VS_o;

    chr_scan_fetch dut (
        .CK_i   (CK_i),
        .ARST_i (ARST_i),
        .VS_i   (VS_i),
        .DE_i   (DE_i),
        .RAs_o  (RAs_o),
        .RDs_i  (RDs_i),
        .FAs_o  (FAs_o),
        .FDs_i  (FDs_i),
        .PIX_o  (PIX_o),
        .DE_o   (DE_o),
        .VS_o   (VS_o)
    );

    always #5 CK_i = ~CK_i;

    // One-register synchronous memories: together with the DUT's own address registers this gives 2-cycle latencies.
    logic [7:0] vram [4096];
    logic [7:0] font [4096];
    always @(posedge CK_i) begin
        RDs_i <= vram[RAs_o];
        FDs_i <= font[FAs_o];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel of input cycle c comes from the glyph whose slot most recently started.
    int         m_px, m_gl, m_row, cyc, g_start, exp_ras, exp_fa;
    bit         m_de_prev;
    logic [7:0] g_bits;
    bit         e_pix [8];
    bit         e_de [8];
    bit         e_vs [8];
    bit         e_fetch [8];
    int         e_fa [8];

    always @(negedge CK_i) begin
        int i5, i3, addr, off;
        bit slot, fetch, pix;
        if (ARST_i) begin
            m_px = 0; m_gl = 0; m_row = 0; cyc = 0; g_start = 0;
            exp_ras = 0; exp_fa = 0; m_de_prev = 0; g_bits = 8'h00;
            for (int i = 0; i < 8; i++) begin
                e_pix[i] = 0; e_de[i] = 0; e_vs[i] = 0; e_fetch[i] = 0; e_fa[i] = 0;
            end
        end else begin
            i5 = (cyc + 3) & 7;
            i3 = (cyc + 5) & 7;
            chk("pix", PIX_o, e_pix[i5]);
            chk("de_o", DE_o, e_de[i5]);
            chk("vs_o", VS_o, e_vs[i5]);
            if (e_fetch[i3]) exp_fa = e_fa[i3];
            chk("fas", FAs_o, exp_fa);
            chk("ras", RAs_o, exp_ras);

            slot  = (m_px % 8) == 0;
            fetch = DE_i && slot && (m_px / 8 < 80);
            addr  = m_row * 80 + m_px / 8;
            if (slot) begin
                g_start = cyc;
                g_bits  = fetch ? font[{vram[addr[11:0]], m_gl[3:0]}] : 8'h00;
            end
            off = cyc - g_start;
            pix = 0;
            if (DE_i && off < 8) pix = g_bits[7 - off];
            e_pix[cyc & 7]   = pix;
            e_de[cyc & 7]    = DE_i;
            e_vs[cyc & 7]    = VS_i;
            e_fetch[cyc & 7] = fetch;
            e_fa[cyc & 7]    = {20'd0, vram[addr[11:0]], m_gl[3:0]};
            if (fetch) exp_ras = addr;

            if (VS_i) begin
                m_px = 0; m_gl = 0; m_row = 0;
            end else begin
                if (m_de_prev && !DE_i) begin
                    m_gl = (m_gl + 1) % 16;
                    if (m_gl == 0) m_row = (m_row + 1) % 30;
                end
                m_px = DE_i ? m_px + 1 : 0;
            end
            m_de_prev = DE_i;
            cyc++;
        end
    end

    logic [11:0] snap_ras, snap_fas;
    logic        snap_pix, snap_deo;
    int          deo_cnt;

    task automatic step(input bit de, input bit vs);
        DE_i = de;
        VS_i = vs;
        @(negedge CK_i);
        snap_ras = RAs_o;
        snap_fas = FAs_o;
        snap_pix = PIX_o;
        snap_deo = DE_o;
        if (DE_o) deo_cnt++;
        @(posedge CK_i);
        #1;
    endtask

    task automatic line(input int len, input int gap, input int vs_px);
        for (int p = 0; p < len; p++) step(1'b1, p == vs_px);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
    endtask

    typedef struct {
        bit vs;
        int len;
        int exp_ras;
        int exp_deo;
    } vec_t;
    vec_t tbl [7];

    logic [7:0] pat;

    initial begin
        ARST_i = 1'b1;
        DE_i   = 1'b0;
        VS_i   = 1'b0;
        deo_cnt = 0;
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 8'($urandom);
            font[i] = 8'($urandom);
        end
        tbl[0] = '{1'b1, 640, 79, 640};
        tbl[1] = '{1'b0, 700, 79, 700};
        tbl[2] = '{1'b0, 13,  1,  13};
        tbl[3] = '{1'b0, 9,   1,  9};
        tbl[4] = '{1'b0, 8,   0,  8};
        tbl[5] = '{1'b1, 100, 12, 100};
        tbl[6] = '{1'b0, 1,   0,  1};

        repeat (3) @(posedge CK_i);
        #1;
        chk("rst_pix", PIX_o, 0);
        chk("rst_de_o", DE_o, 0);
        chk("rst_vs_o", VS_o, 0);
        chk("rst_ras", RAs_o, 0);
        chk("rst_fas", FAs_o, 0);
        ARST_i = 1'b0;
        step(0, 0);

        // Line-length table: last fetch address and number of DE_o cycles per line.
        for (int k = 0; k < 7; k++) begin
            if (tbl[k].vs) begin
                step(0, 1);
                step(0, 0);
            end
            deo_cnt = 0;
            line(tbl[k].len, 8, -1);
            chk("tbl_ras", snap_ras, tbl[k].exp_ras);
            chk("tbl_deo", deo_cnt, tbl[k].exp_deo);
        end

        // Pixel alignment: code 0x41 line 0 = 0xA5 appears L=5 cycles after DE rise.
        vram[0] = 8'h41;
        font[12'h410] = 8'hA5;
        pat = 8'hA5;
        step(0, 1);
        repeat (8) step(0, 0);
        for (int k = 0; k < 13; k++) begin
            step(1, 0);
            if (k < 5) begin
                chk("align_de_o_low", snap_deo, 0);
            end else begin
                chk("align_de_o_high", snap_deo, 1);
                chk("align_pix", snap_pix, pat[12 - k]);
            end
        end
        repeat (627) step(1, 0);
        repeat (8) step(0, 0);

        // Font address with gl=3 lands exactly two cycles after the RAs_o update.
        vram[0] = 8'h7F;
        step(0, 1);
        step(0, 0);
        repeat (3) line(8, 8, -1);
        for (int k = 0; k < 4; k++) begin
            step(1, 0);
            if (k == 1) chk("fa_ras", snap_ras, 0);
            if (k == 2) chk("fa_prev", snap_fas, 12'h7F2);
            if (k == 3) chk("fa_new", snap_fas, 12'h7F3);
        end
        repeat (4) step(1, 0);
        repeat (8) step(0, 0);

        // Address sweep over full lines; line 17 is the second text row.
        step(0, 1);
        step(0, 0);
        for (int ln = 0; ln < 17; ln++) begin
            line(640, 8, -1);
            if (ln == 0)  chk("sweep_row0", snap_ras, 79);
            if (ln == 16) chk("sweep_row1", snap_ras, 159);
        end

        // Reset asserted mid-line with DE high.
        repeat (50) step(1, 0);
        ARST_i = 1'b1;
        #1;
        chk("arst_pix", PIX_o, 0);
        chk("arst_de_o", DE_o, 0);
        chk("arst_vs_o", VS_o, 0);
        chk("arst_ras", RAs_o, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        ARST_i = 1'b0;
        step(0, 0);
        step(0, 1);
        step(0, 0);
        for (int k = 0; k < 16; k++) begin
            step(1, 0);
            if (k == 1) chk("arst_first_ras", snap_ras, 0);
            if (k == 3) chk("arst_first_fas", snap_fas, {vram[0], 4'h0});
        end
        repeat (8) step(0, 0);

        // Full frame of short lines: row wraps after 30 rows of 16 glyph lines.
        step(0, 1);
        step(0, 0);
        for (int ln = 0; ln <= 480; ln++) begin
            line(8, 4, -1);
            if (ln == 16)  chk("wrap_row1", snap_ras, 80);
            if (ln == 479) chk("wrap_row29", snap_ras, 2320);
            if (ln == 480) chk("wrap_row0", snap_ras, 0);
        end
        repeat (4) step(0, 0);

        // VS at px=100 of line 5: next fetch is address 0 with glyph line 0.
        step(0, 1);
        step(0, 0);
        repeat (5) line(8, 8, -1);
        repeat (100) step(1, 0);
        step(1, 1);
        step(1, 0);
        step(1, 0);
        chk("vs_mid_ras", snap_ras, 0);
        step(1, 0);
        step(1, 0);
        chk("vs_mid_fas", snap_fas, {vram[0], 4'h0});
        repeat (535) step(1, 0);
        repeat (8) step(0, 0);

        // Random lines, gaps and VS positions against the reference model.
        for (int n = 0; n < 30; n++) begin
            int len, gap, vsp;
            len = int'($urandom_range(1, 720));
            gap = int'($urandom_range(1, 12));
            vsp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            if ($urandom_range(0, 5) == 0) step(0, 1);
            line(len, gap, vsp);
        end
        repeat (10) step(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
